// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple request ports onto a single APB master.
// One transfer in flight at a time; completion is reported as a one-cycle rsp_valid pulse to the owner.
//
// state  | meaning
// IDLE   | no transfer; grant the next requester round-robin
// SETUP  | APB setup phase (psel=1, penable=0), exactly one cycle
// ACCESS | APB access phase, wait for pready or timeout
module apb_mst_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_AW-1:0]         paddr,
  output logic [APB_DW-1:0]         pwdata,
  input  logic                      pready,
  input  logic [APB_DW-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Abort fires on the ACCESS cycle whose increment would make the count reach TIMEOUT_CYC.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_gnt, gnt_idx, cand, owner;
  logic          gnt_found, accept, done, timeout;
  logic [CW-1:0] wait_cnt;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_gnt;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_gnt) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign timeout = (TIMEOUT_CYC > 0) && (state == ACCESS) && !pready && (wait_cnt == CNT_LAST);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    psel      = 1'b0;
    penable   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = SETUP;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      last_gnt  <= IW'(NUM_REQ - 1);
      owner     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        last_gnt <= gnt_idx;
        owner    <= gnt_idx;
        paddr    <= req_addr[gnt_idx*APB_AW +: APB_AW];
        pwrite   <= req_write[gnt_idx];
        pwdata   <= req_wdata[gnt_idx*APB_DW +: APB_DW];
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 1'b1;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err          <= pslverr;
        rsp_rdata        <= pwrite ? '0 : prdata;
      end else if (timeout) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err          <= 1'b1;
        rsp_rdata        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed bench for apb_mst_arbiter: a default instance plus a TIMEOUT_CYC=4 instance,
// one vector table of single transfers, then contention and reset-mid-ACCESS sequences.
module tb_apb_mst_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  logic             use_to;
  logic [NR-1:0]    drv_valid;
  logic             drv_pready;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    prdata;
  logic             pslverr;

  logic [NR-1:0] a_valid, a_ready, a_rsp_valid, b_valid, b_ready, b_rsp_valid;
  logic [DW-1:0] a_rsp_rdata, a_pwdata, b_rsp_rdata, b_pwdata;
  logic [AW-1:0] a_paddr, b_paddr;
  logic a_rsp_err, a_psel, a_penable, a_pwrite, a_pready;
  logic b_rsp_err, b_psel, b_penable, b_pwrite, b_pready;

  assign a_valid  = use_to ? '0 : drv_valid;
  assign b_valid  = use_to ? drv_valid : '0;
  assign a_pready = use_to ? 1'b0 : drv_pready;
  assign b_pready = use_to ? drv_pready : 1'b0;

  logic [NR-1:0] m_ready, m_rsp_valid;
  logic [DW-1:0] m_rsp_rdata, m_pwdata;
  logic [AW-1:0] m_paddr;
  logic m_rsp_err, m_psel, m_penable, m_pwrite;

  assign m_ready     = use_to ? b_ready     : a_ready;
  assign m_rsp_valid = use_to ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_rdata = use_to ? b_rsp_rdata : a_rsp_rdata;
  assign m_rsp_err   = use_to ? b_rsp_err   : a_rsp_err;
  assign m_psel      = use_to ? b_psel      : a_psel;
  assign m_penable   = use_to ? b_penable   : a_penable;
  assign m_pwrite    = use_to ? b_pwrite    : a_pwrite;
  assign m_paddr     = use_to ? b_paddr     : a_paddr;
  assign m_pwdata    = use_to ? b_pwdata    : a_pwdata;

  apb_mst_arbiter #(.NUM_REQ(NR), .APB_AW(AW), .APB_DW(DW)) dut (
    .pclk(pclk), .prst(prst), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .psel(a_psel), .penable(a_penable), .pwrite(a_pwrite), .paddr(a_paddr),
    .pwdata(a_pwdata), .pready(a_pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_mst_arbiter #(.NUM_REQ(NR), .APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYC(4)) dut_to (
    .pclk(pclk), .prst(prst), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr),
    .pwdata(b_pwdata), .pready(b_pready), .prdata(prdata), .pslverr(pslverr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  typedef struct {
    bit          use_to;
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;   // ACCESS cycles with pready low before the final ACCESS cycle
    bit          tmo;     // slave never answers; final ACCESS cycle also has pready low
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic do_xfer(input vec_t v);
    logic [NR-1:0] onehot;
    onehot = '0;
    onehot[v.port] = 1'b1;
    use_to = v.use_to;
    req_write = '0;
    req_write[v.port] = v.wr;
    req_addr[v.port*AW +: AW]  = v.addr;
    req_wdata[v.port*DW +: DW] = v.wdata;
    drv_pready = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    drv_valid  = onehot;
    #1;
    chk("ready", m_ready, onehot);
    chk("idle_psel", m_psel, 0);
    cyc();
    drv_valid = '0;
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    req_write = ~req_write;
    #1;
    chk("setup_sel_en", {m_psel, m_penable}, 2'b10);
    chk("setup_paddr", m_paddr, v.addr);
    chk("setup_pwrite", m_pwrite, v.wr);
    if (v.wr) chk("setup_pwdata", m_pwdata, v.wdata);
    for (int i = 0; i <= v.waits; i++) begin
      cyc();
      drv_pready = (i == v.waits) && !v.tmo;
      prdata     = v.prdata;
      pslverr    = v.slverr;
      #1;
      chk("access_sel_en", {m_psel, m_penable}, 2'b11);
      chk("access_paddr", m_paddr, v.addr);
      if (v.wr) chk("access_pwdata", m_pwdata, v.wdata);
      chk("access_no_rsp", m_rsp_valid, 0);
    end
    cyc();
    drv_pready = 1'b0;
    pslverr    = 1'b0;
    prdata     = 32'h0BAD_0BAD;
    #1;
    chk("rsp_valid", m_rsp_valid, onehot);
    chk("rsp_rdata", m_rsp_rdata, v.exp_rdata);
    chk("rsp_err", m_rsp_err, v.exp_err);
    chk("rsp_psel", {m_psel, m_penable}, 2'b00);
    cyc();
    #1;
    chk("rsp_pulse", m_rsp_valid, 0);
    chk("rsp_err_pulse_psel", m_psel, 0);
  endtask

  initial begin
    int cnt0, cnt1, ngrant, exp_port;

    //        use_to port wr  addr           wdata          waits tmo prdata         err  exp_rdata      exp_err
    vecs[0] = '{1'b0, 0, 1'b0, 32'h0000_1000, 32'h0,         0, 1'b0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0};
    vecs[1] = '{1'b0, 1, 1'b1, 32'h0000_1004, 32'h0000_5A5A, 5, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 0, 1'b0, 32'h0000_2000, 32'h0,         0, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
    vecs[3] = '{1'b0, 1, 1'b0, 32'h0000_3008, 32'h0,         2, 1'b0, 32'hA5A5_0003, 1'b0, 32'hA5A5_0003, 1'b0};
    vecs[4] = '{1'b0, 1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 1'b0, 32'h5555_AAAA, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 0, 1'b0, 32'h0000_4000, 32'h0,         3, 1'b1, 32'h7777_7777, 1'b0, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 1, 1'b0, 32'h0000_4004, 32'h0,         0, 1'b0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0};
    vecs[7] = '{1'b1, 0, 1'b1, 32'h0000_4008, 32'h0000_BEEF, 3, 1'b0, 32'h9999_9999, 1'b0, 32'h0,         1'b0};
    vecs[8] = '{1'b1, 1, 1'b0, 32'h0000_400C, 32'h0,         3, 1'b0, 32'h3333_4444, 1'b0, 32'h3333_4444, 1'b0};

    use_to     = 1'b0;
    drv_valid  = '0;
    drv_pready = 1'b0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    prdata     = '0;
    pslverr    = 1'b0;
    prst       = 1'b1;
    #1;
    chk("rst_sel_en", {a_psel, a_penable}, 2'b00);
    chk("rst_pwrite", a_pwrite, 0);
    chk("rst_paddr", a_paddr, 0);
    chk("rst_pwdata", a_pwdata, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_rsp_err", a_rsp_err, 0);
    chk("rst_ready", a_ready, 0);
    @(negedge pclk);
    prst = 1'b0;
    cyc();

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Contention: both ports request continuously, zero-wait slave.
    use_to = 1'b0;
    prst = 1'b1;
    #1;
    prst = 1'b0;
    req_write  = '0;
    drv_valid  = 2'b11;
    drv_pready = 1'b1;
    prdata     = 32'h0000_00C0;
    cnt0 = 0;
    cnt1 = 0;
    ngrant = 0;
    exp_port = 0;
    for (int c = 0; c <= 24; c++) begin
      #1;
      if (c < 24 && m_ready != 2'b00) begin
        chk("cont_grant", m_ready, (exp_port == 0) ? 2'b01 : 2'b10);
        exp_port = 1 - exp_port;
        ngrant++;
      end
      if (c >= 1) begin
        if (m_rsp_valid[0]) cnt0++;
        if (m_rsp_valid[1]) cnt1++;
      end
      cyc();
    end
    chk("cont_grants", ngrant, 8);
    chk("cont_rsp0", cnt0, 4);
    chk("cont_rsp1", cnt1, 4);
    drv_valid = '0;
    repeat (4) cyc();

    // Reset mid-ACCESS: port 0 owns the bus when prst hits.
    drv_pready = 1'b0;
    req_addr[0 +: AW] = 32'h0000_5000;
    drv_valid = 2'b01;
    #1;
    chk("rma_ready", m_ready, 2'b01);
    cyc();
    drv_valid = '0;
    cyc();
    cyc();
    #1;
    chk("rma_access", {m_psel, m_penable}, 2'b11);
    #2;
    prst = 1'b1;
    #1;
    chk("rma_psel_drop", {m_psel, m_penable}, 2'b00);
    chk("rma_paddr", m_paddr, 0);
    @(negedge pclk);
    prst = 1'b0;
    drv_pready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rma_no_rsp", m_rsp_valid, 0);
      cyc();
    end
    drv_valid = 2'b11;
    #1;
    chk("rma_first_grant", m_ready, 2'b01);
    drv_valid = '0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
